// File: rtl/revo_trigger_encoder_509.sv
// Revolution-marker trigger encoder for the 509 MHz RF clock domain.
// Emits a clock/4 reference, its trigger-encoded copy and a flag word.
module revo_trigger_encoder_509 #(
  parameter int          TRGSTREAM_WIDTH  = 12,
  parameter int          TRG_MAX_DURATION = 6,
  parameter logic [7:0]  WORD_TRG         = 8'hF4,
  parameter logic [7:0]  WORD_IDLE        = 8'hF2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       revo_in,
  output logic       clock127_out,
  output logic       trg_out,
  output logic       trg_copy_out,
  output logic       trg_n_out,
  output logic       long_revo,
  output logic [7:0] word_out,
  output logic [3:0] phase_out
);

  localparam int W  = TRGSTREAM_WIDTH;
  localparam int LW = TRG_MAX_DURATION;
  localparam int UW = W - LW;

  logic [3:0]    phase_q, phase_d;
  logic [W-1:0]  history_q, history_d;
  logic [UW-1:0] upper_q, upper_d;
  logic [LW-1:0] lower_q, lower_d;
  logic          u_q, u_d;
  logic          l_q, l_d;
  logic          should_q, should_d;
  logic          trg_q, trg_d;
  logic          trg_n_q, trg_n_d;
  logic          clk_q, clk_d;
  logic          tout_q, tout_d;
  logic [7:0]    word_q, word_d;

  always_comb begin
    phase_d   = {phase_q[2:0], phase_q[3]};
    history_d = {history_q[W-2:0], revo_in};
    upper_d   = upper_q;
    lower_d   = lower_q;
    u_d       = u_q;
    l_d       = l_q;
    should_d  = should_q;
    trg_d     = trg_q;
    trg_n_d   = trg_n_q;
    unique case (1'b1)
      phase_q[0]: begin
        trg_d   = should_q;
        trg_n_d = ~should_q;
        upper_d = history_q[W-1:LW];
        lower_d = history_q[LW-1:0];
      end
      phase_q[1]: begin
        u_d = |upper_q;
        l_d = |lower_q;
      end
      phase_q[2]: should_d = 1'b0;
      phase_q[3]: if (l_q) should_d = 1'b1;
      default: ;
    endcase
    // encode against the trigger value that lands on this same edge
    clk_d  = phase_q[3] | phase_q[0];
    tout_d = clk_d ^ trg_d;
    word_d = trg_d ? WORD_TRG : WORD_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q   <= 4'b0001;
      history_q <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
      u_q       <= 1'b0;
      l_q       <= 1'b0;
      should_q  <= 1'b0;
      trg_q     <= 1'b0;
      trg_n_q   <= 1'b1;
      clk_q     <= 1'b0;
      tout_q    <= 1'b0;
      word_q    <= WORD_IDLE;
    end else begin
      phase_q   <= phase_d;
      history_q <= history_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      u_q       <= u_d;
      l_q       <= l_d;
      should_q  <= should_d;
      trg_q     <= trg_d;
      trg_n_q   <= trg_n_d;
      clk_q     <= clk_d;
      tout_q    <= tout_d;
      word_q    <= word_d;
    end
  end

  assign clock127_out = clk_q;
  assign trg_out      = tout_q;
  assign trg_copy_out = trg_q;
  assign trg_n_out    = trg_n_q;
  assign long_revo    = u_q;
  assign word_out     = word_q;
  assign phase_out    = phase_q;

endmodule

// File: tb/tb_revo_trigger_encoder_509.sv
// Directed bench for revo_trigger_encoder_509.
// Trigger windows are offsets from the edge sampling the first revo bit.
module tb_revo_trigger_encoder_509;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       revo_in = 1'b0;
  logic       clock127_out;
  logic       trg_out;
  logic       trg_copy_out;
  logic       trg_n_out;
  logic       long_revo;
  logic [7:0] word_out;
  logic [3:0] phase_out;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int rises = 0;
  logic prev_trg = 1'b0;

  revo_trigger_encoder_509 dut (
    .clock(clock),
    .reset(reset),
    .revo_in(revo_in),
    .clock127_out(clock127_out),
    .trg_out(trg_out),
    .trg_copy_out(trg_copy_out),
    .trg_n_out(trg_n_out),
    .long_revo(long_revo),
    .word_out(word_out),
    .phase_out(phase_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    ecount++;
  endtask

  task automatic test_reset();
    logic [3:0] ep;
    logic       ecl;
    reset = 1'b0;
    revo_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (phase_out !== 4'b0001) begin
      errors++;
      $display("FAIL rst_phase got %b want 0001", phase_out);
    end
    checks++;
    if (clock127_out !== 1'b0 || trg_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_clk got %b/%b want 0/0", clock127_out, trg_out);
    end
    checks++;
    if (trg_copy_out !== 1'b0 || trg_n_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_trg got %b/%b want 0/1", trg_copy_out, trg_n_out);
    end
    checks++;
    if (word_out !== 8'hF2 || long_revo !== 1'b0) begin
      errors++;
      $display("FAIL rst_word got %h/%b want f2/0", word_out, long_revo);
    end
    reset = 1'b1;
    ecount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ep = 4'b0001 << (ecount % 4);
      ecl = (ecount % 4) <= 1;
      checks++;
      if (phase_out !== ep || clock127_out !== ecl) begin
        errors++;
        $display("FAIL ring e%0d got %b/%b want %b/%b",
                 ecount, phase_out, clock127_out, ep, ecl);
      end
      checks++;
      if (trg_copy_out !== 1'b0 || word_out !== 8'hF2) begin
        errors++;
        $display("FAIL idle e%0d got %b/%h want 0/f2",
                 ecount, trg_copy_out, word_out);
      end
    end
  endtask

  // res: ecount%4 before the first sampled edge; lo/hi: trg window
  task automatic test_pulse(input int len, input bit tog,
                            input int res, input int lo,
                            input int hi, input string nm);
    logic exp;
    logic ecl;
    revo_in = 1'b0;
    for (int k = 0; k < 4 && (ecount % 4) != res; k++) tick();
    for (int i = 0; i < len + 50; i++) begin
      revo_in = (i < len) && (!tog || (i % 2) == 0);
      tick();
      exp = (i >= lo) && (i <= hi);
      ecl = (ecount % 4) <= 1;
      checks++;
      if (trg_copy_out !== exp || trg_n_out !== !exp) begin
        errors++;
        $display("FAIL %s_trg i%0d got %b/%b want %b",
                 nm, i, trg_copy_out, trg_n_out, exp);
      end
      checks++;
      if (word_out !== (exp ? 8'hF4 : 8'hF2)) begin
        errors++;
        $display("FAIL %s_word i%0d got %h want %h",
                 nm, i, word_out, exp ? 8'hF4 : 8'hF2);
      end
      checks++;
      if (clock127_out !== ecl || trg_out !== (ecl ^ exp)) begin
        errors++;
        $display("FAIL %s_enc i%0d got %b/%b want %b/%b",
                 nm, i, clock127_out, trg_out, ecl, ecl ^ exp);
      end
      if ((ecount % 4) == 2) begin
        checks++;
        if ((clock127_out ^ trg_out) !== exp) begin
          errors++;
          $display("FAIL %s_dec i%0d got %b want %b",
                   nm, i, clock127_out ^ trg_out, exp);
        end
      end
      if (len >= 12 && !tog && i == 10) begin
        checks++;
        if (long_revo !== 1'b1) begin
          errors++;
          $display("FAIL %s_long got %b want 1", nm, long_revo);
        end
      end
      if (trg_copy_out === 1'b1 && prev_trg === 1'b0) rises++;
      prev_trg = trg_copy_out;
    end
    revo_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    rises = 0;
    test_pulse(2, 1'b0, 0, 8, 11, "b2b2");
    test_pulse(8, 1'b0, 0, 8, 19, "b2b8");
    test_pulse(30, 1'b0, 0, 8, 39, "b2b30");
    checks++;
    if (rises !== 3) begin
      errors++;
      $display("FAIL b2b_windows got %0d want 3", rises);
    end
  endtask

  task automatic test_reset_mid();
    revo_in = 1'b0;
    for (int k = 0; k < 4 && (ecount % 4) != 0; k++) tick();
    revo_in = 1'b1;
    tick();
    revo_in = 1'b0;
    repeat (9) tick();
    checks++;
    if (trg_copy_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %b want 1", trg_copy_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (trg_copy_out !== 1'b0 || trg_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_trg got %b/%b want 0/0", trg_copy_out, trg_out);
    end
    checks++;
    if (clock127_out !== 1'b0 || phase_out !== 4'b0001) begin
      errors++;
      $display("FAIL mid_clk got %b/%b want 0/0001",
               clock127_out, phase_out);
    end
    checks++;
    if (trg_n_out !== 1'b1 || word_out !== 8'hF2) begin
      errors++;
      $display("FAIL mid_word got %b/%h want 1/f2", trg_n_out, word_out);
    end
    repeat (2) tick();
    reset = 1'b1;
    ecount = 0;
    tick();
    checks++;
    if (phase_out !== 4'b0010 || clock127_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart got %b/%b want 0010/1",
               phase_out, clock127_out);
    end
  endtask

  initial begin
    test_reset();
    test_pulse(1, 1'b0, 0, 8, 11, "single");
    test_pulse(1, 1'b0, 2, 6, 13, "twoframe");
    test_pulse(30, 1'b0, 0, 8, 39, "long");
    test_pulse(15, 1'b1, 0, 8, 27, "toggle");
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
